// File: rtl/mem_ctrl.sv
// Byte-serial arbiter sharing one synchronous RAM port between instruction fetch and load/store.
// MEM has fixed priority; each access is sequenced as consecutive little-endian byte cycles.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_rdy_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_rdy_o,
    output logic [31:0]       mem_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t              state_q, state_n;
    logic [2:0]          cnt_q, cnt_n;
    logic [2:0]          len_q, len_n;
    logic                own_mem_q, own_mem_n;
    logic                we_q, we_n;
    logic [ADDR_W-1:0]   base_q, base_n;
    logic [31:0]         wdata_q, wdata_n;
    logic [31:0]         buf_q, buf_n;
    logic                last;
    logic [1:0]          rd_idx;

    logic                if_rdy_n, mem_rdy_n, wr_n;
    logic [31:0]         if_data_n, mem_rdata_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [7:0]          dout_n;

    // Address bits above ADDR_W are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

    // Read data arrives one cycle after its address, so it belongs to byte cnt-1.
    assign rd_idx = 2'(cnt_q - 3'd1);

    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            2'b00:   size_len = 3'd1;
            2'b01:   size_len = 3'd2;
            default: size_len = 3'd4;
        endcase
    endfunction

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        len_n       = len_q;
        own_mem_n   = own_mem_q;
        we_n        = we_q;
        base_n      = base_q;
        wdata_n     = wdata_q;
        buf_n       = buf_q;
        last        = 1'b0;
        if_rdy_n    = 1'b0;
        mem_rdy_n   = 1'b0;
        if_data_n   = if_data_o;
        mem_rdata_n = mem_rdata_o;
        addr_n      = '0;
        wr_n        = 1'b0;
        dout_n      = '0;

        unique case (state_q)
            IDLE: begin
                if (mem_req_i || if_req_i) begin
                    own_mem_n = mem_req_i;
                    we_n      = mem_req_i & mem_we_i;
                    len_n     = mem_req_i ? size_len(mem_size_i) : 3'd4;
                    base_n    = mem_req_i ? mem_addr_i[ADDR_W-1:0] : if_addr_i[ADDR_W-1:0];
                    wdata_n   = mem_wdata_i;
                    cnt_n     = '0;
                    buf_n     = '0;
                    state_n   = XFER;
                    addr_n    = base_n;
                    wr_n      = we_n;
                    dout_n    = mem_wdata_i[7:0];
                end
            end
            XFER: begin
                if (!we_q && cnt_q != 3'd0) begin
                    buf_n[{rd_idx, 3'b000} +: 8] = ram_din_i;
                end
                last = we_q ? (cnt_q == len_q - 3'd1) : (cnt_q == len_q);
                if (last) begin
                    state_n = DONE;
                    if (own_mem_q) begin
                        mem_rdy_n = 1'b1;
                        if (!we_q) begin
                            mem_rdata_n = buf_n;
                        end
                    end else begin
                        if_rdy_n  = 1'b1;
                        if_data_n = buf_n;
                    end
                end else begin
                    cnt_n  = cnt_q + 3'd1;
                    addr_n = base_q + ADDR_W'(cnt_n);
                    wr_n   = we_q;
                    dout_n = wdata_q[{2'(cnt_n), 3'b000} +: 8];
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            own_mem_q   <= 1'b0;
            we_q        <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            if_rdy_o    <= 1'b0;
            if_data_o   <= '0;
            mem_rdy_o   <= 1'b0;
            mem_rdata_o <= '0;
            ram_addr_o  <= '0;
            ram_wr_o    <= 1'b0;
            ram_dout_o  <= '0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            len_q       <= len_n;
            own_mem_q   <= own_mem_n;
            we_q        <= we_n;
            base_q      <= base_n;
            wdata_q     <= wdata_n;
            buf_q       <= buf_n;
            if_rdy_o    <= if_rdy_n;
            if_data_o   <= if_data_n;
            mem_rdy_o   <= mem_rdy_n;
            mem_rdata_o <= mem_rdata_n;
            ram_addr_o  <= addr_n;
            ram_wr_o    <= wr_n;
            ram_dout_o  <= dout_n;
        end
    end

endmodule
